// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared types for the elevator dispatcher.
//   FW        : floor-number width, matches the mover's floor bus
//   floor_t   : one floor number (1-based, 0 is never a real floor)
//   state_e   : dispatcher FSM states
//   floor_of  : maps a pending/button bit index to its floor number
// -----------------------------------------------------------------------------
package elevator_pkg;

   localparam int unsigned FW = 4;

   typedef logic [FW-1:0] floor_t;

   typedef enum logic [2:0] {
      StSelect,
      StIssue,
      StMove,
      StDoor,
      StIdle
   } state_e;

   // Bit i of a request vector belongs to floor i+1.
   function automatic floor_t floor_of(input int unsigned idx);
      return floor_t'(idx + 1);
   endfunction

endpackage

// File: rtl/elevator_dispatch_pick.sv
// -----------------------------------------------------------------------------
// elev_req_pick
// Combinational search over the pending-request vector relative to the car.
// Inputs:
//   pending     latched requests, bit i = floor i+1
//   now_floor   current floor from the mover
//   dir_up      current sweep direction
// Outputs:
//   found_above / floor_above   nearest pending floor strictly above the car
//   found_below / floor_below   nearest pending floor strictly below the car
//   hit_here                    pending bit at the car's floor is set
//   found_next / floor_next     SCAN choice: sweep direction first, then reverse
//   flip                        floor_next lies against the sweep direction
// -----------------------------------------------------------------------------
module elev_req_pick
   import elevator_pkg::*;
#(
   parameter int unsigned NUM_FLOORS = 8
) (
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [FW-1:0]         now_floor,
   input  logic                  dir_up,
   output logic                  found_above,
   output logic [FW-1:0]         floor_above,
   output logic                  found_below,
   output logic [FW-1:0]         floor_below,
   output logic                  hit_here,
   output logic                  found_next,
   output logic [FW-1:0]         floor_next,
   output logic                  flip
);

   // Directional nearest-floor search. Ascending scan: the first hit above is
   // the nearest above, the last hit below is the nearest below.
   always_comb begin
      found_above = 1'b0;
      floor_above = '0;
      found_below = 1'b0;
      floor_below = '0;
      hit_here    = 1'b0;
      for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
         if (pending[i]) begin
            if (floor_of(i) > now_floor && !found_above) begin
               found_above = 1'b1;
               floor_above = floor_of(i);
            end
            if (floor_of(i) < now_floor) begin
               found_below = 1'b1;
               floor_below = floor_of(i);
            end
            if (floor_of(i) == now_floor) begin
               hit_here = 1'b1;
            end
         end
      end
   end

   // SCAN preference: keep going the way we are heading, reverse only if empty.
   always_comb begin
      found_next = 1'b0;
      floor_next = '0;
      flip       = 1'b0;
      if (dir_up) begin
         if (found_above) begin
            found_next = 1'b1;
            floor_next = floor_above;
         end else if (found_below) begin
            found_next = 1'b1;
            floor_next = floor_below;
            flip       = 1'b1;
         end
      end else begin
         if (found_below) begin
            found_next = 1'b1;
            floor_next = floor_below;
         end else if (found_above) begin
            found_next = 1'b1;
            floor_next = floor_above;
            flip       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/elevator_dispatch.sv
// -----------------------------------------------------------------------------
// elevator_dispatch
// Dispatcher and door sequencer on the command side of the floor mover.
// Latches call buttons, picks the next target with a SCAN policy, drives
// des_floor to the mover and times the door at each served floor.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req_btn      call buttons, bit i = floor i+1, level or pulse
//   now_floor    current floor from the mover
//   arr          mover arrived flag (now_floor == des_floor, one cycle lag)
//   des_floor    registered target floor to the mover
//   door_open    registered door-open command
//   dir_up       current sweep direction, 1 = up
//   pending      registered unserved requests
//   busy         high in every state except idle
// -----------------------------------------------------------------------------
module elevator_dispatch
   import elevator_pkg::*;
#(
   parameter int unsigned NUM_FLOORS = 8,
   parameter int unsigned DOOR_TIME  = 100
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] req_btn,
   input  logic [FW-1:0]         now_floor,
   input  logic                  arr,
   output logic [FW-1:0]         des_floor,
   output logic                  door_open,
   output logic                  dir_up,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  busy
);

   localparam int unsigned CW = (DOOR_TIME > 1) ? $clog2(DOOR_TIME) : 1;
   localparam logic [CW-1:0] CntLast = CW'(DOOR_TIME - 1);

   state_e                  state_q, state_d;
   floor_t                  des_q, des_d;
   logic                    door_q, door_d;
   logic                    dir_q, dir_d;
   logic [NUM_FLOORS-1:0]   pend_q, pend_d;
   logic [CW-1:0]           cnt_q, cnt_d;

   logic [NUM_FLOORS-1:0]   here_mask;
   logic [NUM_FLOORS-1:0]   des_mask;
   logic                    in_range;
   logic                    req_here;
   logic                    des_pending;

   logic                    found_above, found_below, hit_here, found_next, flip;
   floor_t                  floor_above, floor_below, floor_next;

   logic                    going_up;
   logic                    retarget;
   floor_t                  retarget_floor;

   elev_req_pick #(
      .NUM_FLOORS (NUM_FLOORS)
   ) u_pick (
      .pending     (pend_q),
      .now_floor   (now_floor),
      .dir_up      (dir_q),
      .found_above (found_above),
      .floor_above (floor_above),
      .found_below (found_below),
      .floor_below (floor_below),
      .hit_here    (hit_here),
      .found_next  (found_next),
      .floor_next  (floor_next),
      .flip        (flip)
   );

   // One-hot floor masks. An out-of-range now_floor yields an all-zero mask,
   // so it can never match, clear or reopen anything.
   always_comb begin
      here_mask = '0;
      des_mask  = '0;
      for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
         here_mask[i] = (floor_of(i) == now_floor);
         des_mask[i]  = (floor_of(i) == des_q);
      end
   end

   assign in_range    = |here_mask;
   assign req_here    = |(req_btn & here_mask);
   assign des_pending = |(pend_q & des_mask);

   // En-route pickup: only a floor strictly between the car and the target,
   // on the side the car is travelling towards.
   always_comb begin
      going_up       = (des_q > now_floor);
      retarget       = 1'b0;
      retarget_floor = des_q;
      if (in_range) begin
         if (going_up) begin
            if (found_above && (floor_above < des_q)) begin
               retarget       = 1'b1;
               retarget_floor = floor_above;
            end
         end else begin
            if (found_below && (floor_below > des_q)) begin
               retarget       = 1'b1;
               retarget_floor = floor_below;
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StSelect;
         des_q   <= floor_t'(1);
         door_q  <= 1'b0;
         dir_q   <= 1'b1;
         pend_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         des_q   <= des_d;
         door_q  <= door_d;
         dir_q   <= dir_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      des_d   = des_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StSelect: begin
            if (hit_here && arr) begin
               state_d = StDoor;
               cnt_d   = '0;
            end else if (found_next) begin
               des_d   = floor_next;
               state_d = StIssue;
               if (flip) begin
                  dir_d = ~dir_q;
               end
            end else if (hit_here) begin
               // Request at this floor but the car has not settled yet.
               des_d   = now_floor;
               state_d = StIssue;
            end else if (arr) begin
               state_d = StIdle;
            end else begin
               // Nothing pending and not at target: still homing.
               state_d = StMove;
            end
         end
         StIssue: begin
            // Mover's arr is one cycle stale here.
            state_d = StMove;
         end
         StMove: begin
            if (arr && (now_floor == des_q)) begin
               state_d = des_pending ? StDoor : StSelect;
               cnt_d   = '0;
            end else if (retarget) begin
               des_d   = retarget_floor;
               state_d = StIssue;
            end
         end
         StDoor: begin
            if (req_here) begin
               cnt_d = '0;
            end else if (cnt_q == CntLast) begin
               state_d = StSelect;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StIdle: begin
            des_d = now_floor;
            if (|pend_q) begin
               state_d = StSelect;
            end
         end
         default: begin
            state_d = StSelect;
         end
      endcase
   end

   // Output / request-latch logic. The car's own floor bit stays clear while
   // the door is open or about to open.
   always_comb begin
      door_d = (state_d == StDoor);
      pend_d = pend_q | req_btn;
      if ((state_q == StDoor) || (state_d == StDoor)) begin
         pend_d = pend_d & ~here_mask;
      end
   end

   assign des_floor = des_q;
   assign door_open = door_q;
   assign dir_up    = dir_q;
   assign pending   = pend_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_elevator_dispatch.sv
// -----------------------------------------------------------------------------
// tb_elevator_dispatch
// Directed bench for elevator_dispatch: the bench plays the mover by hand,
// stepping now_floor and raising arr on arrival.
// -----------------------------------------------------------------------------
module tb_elevator_dispatch;

   import elevator_pkg::*;

   logic                clk;
   logic                rst_n;
   logic [7:0]          req_btn;
   floor_t              now_floor;
   logic                arr;
   floor_t              des_floor;
   logic                door_open;
   logic                dir_up;
   logic [7:0]          pending;
   logic                busy;

   int n_checks = 0;
   int n_errors = 0;
   int n_door   = 0;

   elevator_dispatch #(
      .NUM_FLOORS (8),
      .DOOR_TIME  (100)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_btn   (req_btn),
      .now_floor (now_floor),
      .arr       (arr),
      .des_floor (des_floor),
      .door_open (door_open),
      .dir_up    (dir_up),
      .pending   (pending),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Mover model: drop arr for the issue cycle, step one floor per two
   // cycles, and raise arr together with the arrival floor.
   task automatic go(input floor_t target);
      arr = 1'b0;
      step(1);
      for (int k = 0; k < 16 && now_floor != target; k++) begin
         if (target > now_floor) now_floor = now_floor + floor_t'(1);
         else                    now_floor = now_floor - floor_t'(1);
         if (now_floor == target) begin
            arr = 1'b1;
            step(1);
         end else begin
            step(2);
         end
      end
   endtask

   // Count door-open samples (bounded). Optionally press press_mask during
   // the sample whose door counter equals press_at.
   task automatic door_wait(input int press_at, input logic [7:0] press_mask,
                            output int cycles);
      int n;
      n = 0;
      while (door_open === 1'b1 && n < 1000) begin
         if (press_at >= 0 && n == press_at) req_btn = press_mask;
         else                                req_btn = '0;
         if (press_at >= 0 && n == press_at + 1) begin
            check("reopen_pending_clear", pending & press_mask, 8'h00);
         end
         n++;
         step(1);
      end
      req_btn = '0;
      cycles  = n;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      req_btn   = '0;
      now_floor = 4'd1;
      arr       = 1'b1;
      #12;
      // ---- 1: reset, car at 1, nothing pending ----
      check("rst_des", des_floor, 4'd1);
      check("rst_door", door_open, 1'b0);
      check("rst_dir", dir_up, 1'b1);
      check("rst_pending", pending, 8'h00);
      check("rst_busy", busy, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(2);
      check("t1_idle_busy", busy, 1'b0);
      check("t1_idle_des", des_floor, 4'd1);
      check("t1_idle_door", door_open, 1'b0);

      // ---- 2: call floor 5 from floor 1 ----
      req_btn = 8'h10;
      step(1);
      req_btn = '0;
      check("t2_latch", pending, 8'h10);
      step(1);
      check("t2_select_busy", busy, 1'b1);
      step(1);
      check("t2_des", des_floor, 4'd5);
      go(4'd5);
      check("t2_door_on", door_open, 1'b1);
      check("t2_pend_clr", pending, 8'h00);
      door_wait(-1, 8'h00, n_door);
      check("t2_door_len", n_door, 100);
      step(1);
      check("t2_idle", busy, 1'b0);
      check("t2_idle_des", des_floor, 4'd5);

      // ---- 4: at 5 going up with {2,7} pending: 7 first, then 2 ----
      req_btn = 8'h42;
      step(1);
      req_btn = '0;
      step(2);
      check("t4_des7", des_floor, 4'd7);
      check("t4_dir_up", dir_up, 1'b1);
      go(4'd7);
      check("t4_door7", door_open, 1'b1);
      check("t4_pend", pending, 8'h02);
      door_wait(-1, 8'h00, n_door);
      check("t4_door7_len", n_door, 100);
      step(1);
      check("t4_des2", des_floor, 4'd2);
      check("t4_dir_down", dir_up, 1'b0);
      go(4'd2);
      check("t4_door2", door_open, 1'b1);
      door_wait(-1, 8'h00, n_door);
      check("t4_door2_len", n_door, 100);
      step(1);
      check("t4_idle", busy, 1'b0);
      check("t4_idle_pend", pending, 8'h00);

      // ---- 5: door reopen at floor 3 ----
      req_btn = 8'h04;
      step(1);
      req_btn = '0;
      step(2);
      check("t5_des3", des_floor, 4'd3);
      check("t5_dir_flip", dir_up, 1'b1);
      go(4'd3);
      check("t5_door_on", door_open, 1'b1);
      door_wait(60, 8'h04, n_door);
      check("t5_door_len", n_door, 161);
      check("t5_pend", pending, 8'h00);
      step(1);
      check("t5_idle", busy, 1'b0);

      // ---- 6: reset mid-move towards 6, then home to 1 ----
      req_btn = 8'h20;
      step(1);
      req_btn = '0;
      step(2);
      check("t6_des6", des_floor, 4'd6);
      arr = 1'b0;
      step(1);
      now_floor = 4'd4;
      step(2);
      rst_n = 1'b0;
      #1;
      check("t6_rst_des", des_floor, 4'd1);
      check("t6_rst_pend", pending, 8'h00);
      check("t6_rst_door", door_open, 1'b0);
      check("t6_rst_dir", dir_up, 1'b1);
      req_btn = 8'h80;
      step(1);
      check("t6_rst_ignore_btn", pending, 8'h00);
      rst_n   = 1'b1;
      req_btn = '0;
      step(1);
      check("t6_homing_busy", busy, 1'b1);
      check("t6_homing_des", des_floor, 4'd1);
      go(4'd1);
      step(1);
      check("t6_home_idle", busy, 1'b0);
      check("t6_home_des", des_floor, 4'd1);

      // ---- 3: 1 -> 7, pick up 4 en route; request at car floor not taken ----
      req_btn = 8'h40;
      step(1);
      req_btn = '0;
      step(2);
      check("t3_des7", des_floor, 4'd7);
      arr = 1'b0;
      step(1);
      now_floor = 4'd2;
      step(1);
      req_btn = 8'h08;
      step(1);
      req_btn = '0;
      check("t3_pend", pending, 8'h48);
      step(1);
      check("t3_retarget", des_floor, 4'd4);
      go(4'd4);
      check("t3_door4", door_open, 1'b1);
      check("t3_door4_des", des_floor, 4'd4);
      check("t3_door4_pend", pending, 8'h40);
      door_wait(-1, 8'h00, n_door);
      check("t3_door4_len", n_door, 100);
      step(1);
      check("t3_des7_again", des_floor, 4'd7);
      arr = 1'b0;
      step(1);
      now_floor = 4'd5;
      req_btn   = 8'h10;
      step(1);
      req_btn = '0;
      step(1);
      check("t3_no_pickup_here", des_floor, 4'd7);
      check("t3_pend_here", pending, 8'h50);
      now_floor = 4'd6;
      step(2);
      now_floor = 4'd7;
      arr       = 1'b1;
      step(1);
      check("t3_door7", door_open, 1'b1);
      check("t3_door7_pend", pending, 8'h10);
      door_wait(-1, 8'h00, n_door);
      check("t3_door7_len", n_door, 100);
      step(1);
      check("t3_des5", des_floor, 4'd5);
      check("t3_dir_down", dir_up, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
